seg_bcd_formatter: RTL and testbench
====================================

SEG_BCD_FORMATTER -- requirements
Module: seg_bcd_formatter

Interface
REQ-001 SHALL have parameter NUM_CH, default 3: number of binary channels converted per frame (1..8).
REQ-002 SHALL have parameter BIN_W, default 8: width of each binary channel (4..16).
REQ-003 SHALL have parameter DIG, default 2: displayed BCD digits per channel (1..5).
REQ-004 SHALL have port sys_clk  input  1: single clock; all logic on its rising edge.
REQ-005 SHALL have port sys_rst  input  1: reset, synchronous, active-high.
REQ-006 SHALL have port i_start  input  1: frame request pulse.
REQ-007 SHALL have port i_bin  input  NUM_CH*BIN_W: channel k in bits [k*BIN_W +: BIN_W], unsigned.
REQ-008 SHALL have port o_busy  output  1: high from the cycle after an accepted i_start through the DONE cycle.
REQ-009 SHALL have port o_done  output  1: one-cycle pulse when a new frame is committed.
REQ-010 SHALL have port o_bcd  output  NUM_CH*DIG*4: channel k at [(NUM_CH-1-k)*DIG*4 +: DIG*4], i.e. channel 0 in the MS digits, each channel MS digit first.
REQ-011 SHALL have port o_ovf  output  NUM_CH: bit k set when channel k exceeded 10^DIG-1 in the last frame.

Function
REQ-012 SHALL implement FSM states IDLE, LOAD, SHIFT, STORE, DONE.
REQ-013 IDLE: when i_start=1, SHALL snapshot all of i_bin, set channel index to 0, and go to LOAD; i_bin changes after this point SHALL NOT affect the frame.
REQ-014 LOAD (1 cycle): SHALL load the shift register with snapshot channel ch, clear the internal BCD accumulator, set the bit counter to BIN_W, and go to SHIFT.
REQ-015 SHALL size the internal accumulator to NDIG_INT = (BIN_W+2)/3 digits, integer division.
REQ-016 SHIFT (BIN_W cycles): per cycle SHALL add 3 to every accumulator digit >= 5, then shift {accumulator, shift register} left one bit; on the last bit SHALL go to STORE.
REQ-017 STORE (1 cycle): SHALL write the low DIG digits to a shadow buffer for channel ch; if any higher digit is nonzero (value > 10^DIG-1) it SHALL write all-9 digits and set shadow ovf[ch].
REQ-018 When NDIG_INT < DIG, the unused MS digits SHALL be written as 0.
REQ-019 STORE SHALL go to DONE when ch = NUM_CH-1, else increment ch and go to LOAD.
REQ-020 DONE (1 cycle): SHALL copy shadow buffer to o_bcd and shadow ovf to o_ovf together, pulse o_done, and return to IDLE, so o_bcd never shows a mixed frame.
REQ-021 Latency: o_done SHALL be high exactly NUM_CH*(BIN_W+2)+1 cycles after the cycle in which i_start was sampled (31 with defaults).
REQ-022 i_start during any non-IDLE state, including DONE, SHALL be ignored, not queued.
REQ-023 o_bcd and o_ovf SHALL hold their values between DONE cycles.

Reset
REQ-024 While sys_rst=1, the block SHALL set state to IDLE, ch to 0, o_bcd to 0, o_ovf to 0, o_done to 0, o_busy to 0, and the shadow buffer to 0.
REQ-025 Reset mid-frame SHALL abort the frame with no o_done; the first i_start after release SHALL start a fresh frame.

Configuration
REQ-026 With macro SEG_BCD_BLANK_EN defined, STORE SHALL replace each leading zero digit of a channel with 4'hF (blank code), except the channel's LS digit.
REQ-027 Without SEG_BCD_BLANK_EN, leading zeros SHALL be output as 4'h0 and no blanking logic SHALL be synthesised.

Structure
REQ-028 A shared package seg_pkg SHALL hold the FSM state encoding, the blank code 4'hF, and a constant function computing NDIG_INT from BIN_W.
REQ-029 The add-3 digit correction SHALL be a sub-module bcd_dig_adj (4-bit in/out), instantiated NDIG_INT times; everything else SHALL be in seg_bcd_formatter.

Verification (defaults unless stated)
REQ-030 i_bin = {98,75,36} (ch0 = 36), single i_start -> o_done exactly 31 cycles later, o_bcd = 24'h367598, o_ovf = 0, o_busy high for cycles 1..31.
REQ-031 ch1 = 255, others 0 -> ch1 digits = 99, o_ovf = 3'b010; with BIN_W=10, DIG=4 and value 1023 -> digits 1023, ovf = 0.
REQ-032 Second i_start at cycle 10, and i_bin changed at cycle 5 -> only one o_done, result reflects the cycle-0 snapshot.
REQ-033 sys_rst asserted at cycle 15 of a frame -> no o_done, o_bcd = 0; a new i_start then completes normally in 31 cycles.
REQ-034 SEG_BCD_BLANK_EN defined, DIG=3, channel values 5 and 0 -> 12'hFF5 and 12'hFF0; undefined -> 12'h005 and 12'h000.

Source files
------------

// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg_pkg
// Brief    : Shared FSM encoding, blank code and digit sizing for seg_bcd_formatter.
// Revision : 1.0
// ============================================================================
package seg_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_STORE = 3'd3,
    S_DONE  = 3'd4
  } seg_state_t;

  localparam logic [3:0] c_blank_code = 4'hF;

  // Decimal digits needed to hold any BIN_W-bit unsigned value.
  function automatic int ndig_int(input int bin_w);
    return (bin_w + 2) / 3;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_dig_adj.sv
`default_nettype none
// ============================================================================
// Module   : bcd_dig_adj
// Brief    : Double-dabble add-3 correction for one BCD digit.
// Revision : 1.0
// ============================================================================
module bcd_dig_adj (
  input  logic [3:0] i_dig,
  output logic [3:0] o_dig
);

  assign o_dig = (i_dig >= 4'd5) ? (i_dig + 4'd3) : i_dig;

endmodule
`default_nettype wire

// File: rtl/seg_bcd_formatter.sv
`default_nettype none
// ============================================================================
// Module   : seg_bcd_formatter
// Brief    : Frame-based multi-channel binary-to-BCD converter, saturating
//            to all-9 on overflow. Optional SEG_BCD_BLANK_EN blanks leading zeros.
// Revision : 1.0
// ============================================================================
module seg_bcd_formatter #(
  parameter int NUM_CH = 3,
  parameter int BIN_W  = 8,
  parameter int DIG    = 2
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst,
  input  logic                      i_start,
  input  logic [NUM_CH*BIN_W-1:0]   i_bin,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [NUM_CH*DIG*4-1:0]   o_bcd,
  output logic [NUM_CH-1:0]         o_ovf
);
  import seg_pkg::*;

  localparam int c_ndig_int = ndig_int(BIN_W);
  localparam int c_acc_w    = c_ndig_int * 4;
  localparam int c_ext_d    = (c_ndig_int > DIG) ? c_ndig_int : DIG;
  localparam int c_out_w    = DIG * 4;
  localparam int c_ch_w     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int c_cnt_w    = $clog2(BIN_W + 1);

  seg_state_t                  r_state;
  logic [NUM_CH*BIN_W-1:0]     r_snap;
  logic [c_ch_w-1:0]           r_ch;
  logic [BIN_W-1:0]            r_sr;
  logic [c_acc_w-1:0]          r_acc;
  logic [c_cnt_w-1:0]          r_cnt;
  logic [NUM_CH*c_out_w-1:0]   r_shadow;
  logic [NUM_CH-1:0]           r_shadow_ovf;

  logic [c_acc_w-1:0]          w_adj;
  logic [BIN_W-1:0]            w_chan;
  logic [c_ext_d*4-1:0]        w_acc_ext;
  logic [c_out_w-1:0]          w_store;
  logic                        w_store_ovf;
  logic [NUM_CH*c_out_w-1:0]   w_shadow_nxt;
  logic [NUM_CH-1:0]           w_ovf_nxt;
  logic                        w_last_ch;

  for (genvar g = 0; g < c_ndig_int; g++) begin : g_adj
    bcd_dig_adj u_adj (
      .i_dig (r_acc[g*4 +: 4]),
      .o_dig (w_adj[g*4 +: 4])
    );
  end

  assign w_last_ch = (r_ch == c_ch_w'(NUM_CH - 1));

  always_comb begin
    w_chan = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (r_ch == c_ch_w'(k)) w_chan = r_snap[k*BIN_W +: BIN_W];
    end
  end

`ifdef SEG_BCD_BLANK_EN
  logic w_lead;
`endif

  // Zero-extend so digits above the accumulator read as 0 when DIG > NDIG_INT.
  always_comb begin
    w_acc_ext              = '0;
    w_acc_ext[c_acc_w-1:0] = r_acc;
    w_store_ovf            = |(w_acc_ext >> c_out_w);
    w_store                = w_store_ovf ? {DIG{4'h9}} : w_acc_ext[c_out_w-1:0];
`ifdef SEG_BCD_BLANK_EN
    w_lead = 1'b1;
    for (int i = DIG - 1; i >= 1; i--) begin
      if (w_lead && (w_store[i*4 +: 4] == 4'h0)) w_store[i*4 +: 4] = c_blank_code;
      else                                        w_lead = 1'b0;
    end
`endif
  end

  always_comb begin
    w_shadow_nxt = r_shadow;
    w_ovf_nxt    = r_shadow_ovf;
    for (int k = 0; k < NUM_CH; k++) begin
      if (r_ch == c_ch_w'(k)) begin
        w_shadow_nxt[(NUM_CH-1-k)*c_out_w +: c_out_w] = w_store;
        w_ovf_nxt[k]                                  = w_store_ovf;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state      <= S_IDLE;
      r_snap       <= '0;
      r_ch         <= '0;
      r_sr         <= '0;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_shadow     <= '0;
      r_shadow_ovf <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_bcd        <= '0;
      o_ovf        <= '0;
    end else begin
      o_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_snap  <= i_bin;
            r_ch    <= '0;
            o_busy  <= 1'b1;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_sr    <= w_chan;
          r_acc   <= '0;
          r_cnt   <= c_cnt_w'(BIN_W);
          r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          {r_acc, r_sr} <= {w_adj, r_sr} << 1;
          r_cnt         <= r_cnt - 1'b1;
          if (r_cnt == c_cnt_w'(1)) r_state <= S_STORE;
        end
        S_STORE: begin
          r_shadow     <= w_shadow_nxt;
          r_shadow_ovf <= w_ovf_nxt;
          // Outputs update with the complete frame so they are valid in the DONE cycle.
          if (w_last_ch) begin
            o_bcd   <= w_shadow_nxt;
            o_ovf   <= w_ovf_nxt;
            o_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_ch    <= r_ch + 1'b1;
            r_state <= S_LOAD;
          end
        end
        S_DONE: begin
          o_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg_bcd_formatter.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_bcd_formatter
// Brief    : Directed self-checking bench for seg_bcd_formatter (three configurations).
// Revision : 1.0
// ============================================================================
module tb_seg_bcd_formatter;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        i_start;
  logic [23:0] i_bin;
  logic        o_busy, o_done;
  logic [23:0] o_bcd;
  logic [2:0]  o_ovf;

  logic        start_w;
  logic [9:0]  bin_w;
  logic        busy_w, done_w;
  logic [15:0] bcd_w;
  logic [0:0]  ovf_w;

  logic        start_b;
  logic [15:0] bin_b;
  logic        busy_b, done_b;
  logic [23:0] bcd_b;
  logic [1:0]  ovf_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 sys_clk = ~sys_clk;

  seg_bcd_formatter u_dut (
    .sys_clk (sys_clk), .sys_rst (sys_rst), .i_start (i_start), .i_bin (i_bin),
    .o_busy  (o_busy),  .o_done  (o_done),  .o_bcd   (o_bcd),   .o_ovf (o_ovf)
  );

  seg_bcd_formatter #(.NUM_CH(1), .BIN_W(10), .DIG(4)) u_dut_w (
    .sys_clk (sys_clk), .sys_rst (sys_rst), .i_start (start_w), .i_bin (bin_w),
    .o_busy  (busy_w),  .o_done  (done_w),  .o_bcd   (bcd_w),   .o_ovf (ovf_w)
  );

  seg_bcd_formatter #(.NUM_CH(2), .BIN_W(8), .DIG(3)) u_dut_b (
    .sys_clk (sys_clk), .sys_rst (sys_rst), .i_start (start_b), .i_bin (bin_b),
    .o_busy  (busy_b),  .o_done  (done_b),  .o_bcd   (bcd_b),   .o_ovf (ovf_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Runs one default-config frame over a 40-cycle window; cycle 1 follows the start edge.
  task automatic frame(input logic [23:0] bin, input int chg_at, input logic [23:0] bin2,
                       input int re_at, output int first_done, output int n_done,
                       output int n_busy);
    i_bin   = bin;
    i_start = 1'b1;
    tick();
    i_start    = 1'b0;
    first_done = -1;
    n_done     = 0;
    n_busy     = 0;
    for (int c = 1; c <= 40; c++) begin
      if (o_done) begin
        n_done++;
        if (first_done < 0) first_done = c;
      end
      if (o_busy) n_busy++;
      if (c == chg_at) i_bin = bin2;
      i_start = (c == re_at);
      tick();
    end
    i_start = 1'b0;
  endtask

  task automatic run_w(input logic [9:0] v, output int dc);
    bin_w   = v;
    start_w = 1'b1;
    tick();
    start_w = 1'b0;
    dc      = -1;
    for (int c = 1; c <= 30 && dc < 0; c++) begin
      if (done_w) dc = c;
      else        tick();
    end
  endtask

  task automatic run_b(input logic [15:0] v, output int dc);
    bin_b   = v;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    dc      = -1;
    for (int c = 1; c <= 40 && dc < 0; c++) begin
      if (done_b) dc = c;
      else        tick();
    end
  endtask

  initial begin
    int fd, nd, nb;
    sys_rst = 1'b1;
    i_start = 1'b0; i_bin = '0;
    start_w = 1'b0; bin_w = '0;
    start_b = 1'b0; bin_b = '0;
    repeat (3) tick();
    chk("rst_bcd",  o_bcd,  24'h0);
    chk("rst_ovf",  o_ovf,  3'b000);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_done", o_done, 1'b0);
    sys_rst = 1'b0;
    tick();

    frame({8'd98, 8'd75, 8'd36}, 0, 24'h0, 0, fd, nd, nb);
    chk("f1_latency", fd, 31);
    chk("f1_ndone",   nd, 1);
    chk("f1_busy",    nb, 31);
    chk("f1_bcd",     o_bcd, 24'h367598);
    chk("f1_ovf",     o_ovf, 3'b000);

    i_bin = {8'd1, 8'd1, 8'd1};
    repeat (5) tick();
    chk("hold_bcd", o_bcd, 24'h367598);

    frame({8'd0, 8'd255, 8'd0}, 0, 24'h0, 0, fd, nd, nb);
    chk("sat_bcd", o_bcd, 24'h009900);
    chk("sat_ovf", o_ovf, 3'b010);

    frame({8'd10, 8'd0, 8'd199}, 0, 24'h0, 0, fd, nd, nb);
    chk("mix_bcd", o_bcd, 24'h990010);
    chk("mix_ovf", o_ovf, 3'b001);

    frame({8'd1, 8'd2, 8'd3}, 5, {8'd50, 8'd60, 8'd70}, 10, fd, nd, nb);
    chk("snap_ndone",   nd, 1);
    chk("snap_latency", fd, 31);
    chk("snap_busy",    nb, 31);
    chk("snap_bcd",     o_bcd, 24'h030201);

    frame({8'd12, 8'd34, 8'd56}, 0, 24'h0, 31, fd, nd, nb);
    chk("donestart_ndone", nd, 1);
    chk("donestart_busy",  nb, 31);
    chk("donestart_bcd",   o_bcd, 24'h563412);

    // Abort a frame with reset at cycle 15.
    i_bin   = {8'd1, 8'd2, 8'd3};
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    nd = 0;
    for (int c = 1; c < 15; c++) begin
      if (o_done) nd++;
      tick();
    end
    sys_rst = 1'b1;
    repeat (2) tick();
    sys_rst = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (o_done) nd++;
      tick();
    end
    chk("abort_ndone", nd, 0);
    chk("abort_bcd",   o_bcd, 24'h0);
    chk("abort_busy",  o_busy, 1'b0);

    frame({8'd45, 8'd0, 8'd7}, 0, 24'h0, 0, fd, nd, nb);
    chk("post_rst_latency", fd, 31);
    chk("post_rst_bcd",     o_bcd, 24'h070045);

    run_w(10'd1023, fd);
    chk("w_latency", fd, 13);
    chk("w_bcd",     bcd_w, 16'h1023);
    chk("w_ovf",     ovf_w, 1'b0);
    tick();
    run_w(10'd999, fd);
    chk("w_bcd999",  bcd_w, 16'h0999);
    tick();

    run_b({8'd0, 8'd5}, fd);
    chk("b_latency", fd, 21);
`ifdef SEG_BCD_BLANK_EN
    chk("b_bcd_5_0", bcd_b, 24'hFF5FF0);
`else
    chk("b_bcd_5_0", bcd_b, 24'h005000);
`endif
    tick();
    run_b({8'd40, 8'd250}, fd);
`ifdef SEG_BCD_BLANK_EN
    chk("b_bcd_250_40", bcd_b, 24'h250F40);
`else
    chk("b_bcd_250_40", bcd_b, 24'h250040);
`endif
    chk("b_ovf", ovf_b, 2'b00);
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
